// File: rtl/ax_cycle_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ax_cycle_window_ctrl
//  Purpose  : Window sequencer and threshold CSR for the cycle-based
//             approximate-branch decider in the FetchUnit. Tracks entry and
//             exit of approximate code regions seen at commit and drives the
//             decider's cyclecounter / begincycle / threshold inputs so that
//             (elapsed > threshold) can only appear inside an armed window.
//  Ports    : clk, rst_n (async, active low)
//             region_begin / region_end / flush : commit-side window events
//             csr_we / csr_re / csr_addr / csr_wdata / csr_rdata : CSR port
//               addr 0=THRESH(RW) 1=CTRL(RW) 2=STATUS(RO) 3=BEGIN(RO)
//             cyclecounter / begincycle / threshold : decider inputs
//             window_active, expired_pulse : status to the fetch stage
//  Revision : 1.0  initial release
// ============================================================================
module ax_cycle_window_ctrl #(
    parameter int          CNT_WIDTH     = 32,
    parameter int unsigned RST_THRESHOLD = 1000,
    parameter int          EXP_CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 region_begin,
    input  logic                 region_end,
    input  logic                 flush,
    input  logic                 csr_we,
    input  logic                 csr_re,
    input  logic [1:0]           csr_addr,
    input  logic [CNT_WIDTH-1:0] csr_wdata,
    output logic [CNT_WIDTH-1:0] csr_rdata,
    output logic [CNT_WIDTH-1:0] cyclecounter,
    output logic [CNT_WIDTH-1:0] begincycle,
    output logic [CNT_WIDTH-1:0] threshold,
    output logic                 window_active,
    output logic                 expired_pulse
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_active  = 2'd1;
    localparam logic [1:0] c_st_expired = 2'd2;

    localparam logic [1:0] c_addr_thresh = 2'd0;
    localparam logic [1:0] c_addr_ctrl   = 2'd1;
    localparam logic [1:0] c_addr_status = 2'd2;

    localparam logic [CNT_WIDTH-1:0]     c_ones      = '1;
    localparam logic [CNT_WIDTH-1:0]     c_one       = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]     c_rst_thr   = CNT_WIDTH'(RST_THRESHOLD);
    localparam logic [EXP_CNT_WIDTH-1:0] c_exp_ones  = '1;
    localparam logic [EXP_CNT_WIDTH-1:0] c_exp_one   = EXP_CNT_WIDTH'(1);
    localparam int                       c_status_w  = EXP_CNT_WIDTH + 16;

    logic [1:0]               r_state;
    logic [CNT_WIDTH-1:0]     r_abs_cnt;
    logic [CNT_WIDTH-1:0]     r_elapsed;
    logic [CNT_WIDTH-1:0]     r_begin_lat;
    logic [CNT_WIDTH-1:0]     r_thr_shadow;
    logic [CNT_WIDTH-1:0]     r_thr_act;
    logic                     r_en;
    logic                     r_rearm;
    logic [EXP_CNT_WIDTH-1:0] r_exp_cnt;
    logic [CNT_WIDTH-1:0]     r_csr_rdata;
    logic [CNT_WIDTH-1:0]     r_cyclecounter;
    logic [CNT_WIDTH-1:0]     r_begincycle;
    logic [CNT_WIDTH-1:0]     r_threshold;
    logic                     r_window_active;
    logic                     r_expired_pulse;

    logic [1:0]               w_state_nxt;
    logic [CNT_WIDTH-1:0]     w_elapsed_nxt;
    logic [CNT_WIDTH-1:0]     w_elapsed_inc;
    logic [CNT_WIDTH-1:0]     w_thr_act_nxt;
    logic                     w_start;
    logic                     w_expire;
    logic                     w_en_clear;
    logic [c_status_w-1:0]    w_status_raw;
    logic [CNT_WIDTH-1:0]     w_status;
    logic [CNT_WIDTH-1:0]     w_ctrl;
    logic [CNT_WIDTH-1:0]     w_rd_mux;

    // A CTRL write with EN=0 closes the window on the same edge it lands.
    assign w_en_clear = csr_we && (csr_addr == c_addr_ctrl) && !csr_wdata[0];

    assign w_elapsed_inc = (r_elapsed == c_ones) ? r_elapsed : (r_elapsed + c_one);

    always_comb begin
        w_state_nxt   = r_state;
        w_elapsed_nxt = r_elapsed;
        w_start       = 1'b0;
        w_expire      = 1'b0;
        case (r_state)
            c_st_idle: begin
                // flush and region_end both outrank a simultaneous begin
                if (region_begin && r_en && !flush && !region_end)
                    w_start = 1'b1;
            end
            c_st_active: begin
                w_elapsed_nxt = w_elapsed_inc;
                if (flush || region_end) begin
                    w_state_nxt = c_st_idle;
                end else if ((r_elapsed == r_thr_act) && (r_thr_act != c_ones)) begin
                    // An all-ones threshold can never be exceeded, so it never expires.
                    w_state_nxt = c_st_expired;
                    w_expire    = 1'b1;
                end
            end
            c_st_expired: begin
                w_elapsed_nxt = w_elapsed_inc;
                if (flush || region_end)
                    w_state_nxt = c_st_idle;
                else if (region_begin && r_rearm)
                    w_start = 1'b1;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase

        if (w_start) begin
            w_state_nxt   = c_st_active;
            w_elapsed_nxt = '0;
        end

        if (!r_en || w_en_clear) begin
            w_state_nxt   = c_st_idle;
            w_elapsed_nxt = r_elapsed;
            w_start       = 1'b0;
            w_expire      = 1'b0;
        end
    end

    // The live compare value only changes when a window opens.
    assign w_thr_act_nxt = w_start ? r_thr_shadow : r_thr_act;

    assign w_status_raw = {r_exp_cnt, 14'b0, r_state};

    generate
        if (c_status_w >= CNT_WIDTH) begin : g_status_trunc
            assign w_status = w_status_raw[CNT_WIDTH-1:0];
        end else begin : g_status_ext
            assign w_status = {{(CNT_WIDTH-c_status_w){1'b0}}, w_status_raw};
        end
    endgenerate

    assign w_ctrl = {{(CNT_WIDTH-2){1'b0}}, r_rearm, r_en};

    always_comb begin
        w_rd_mux = r_begin_lat;
        case (csr_addr)
            c_addr_thresh: w_rd_mux = r_thr_shadow;
            c_addr_ctrl:   w_rd_mux = w_ctrl;
            c_addr_status: w_rd_mux = w_status;
            default:       w_rd_mux = r_begin_lat;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_abs_cnt    <= '0;
            r_elapsed    <= '0;
            r_begin_lat  <= '0;
            r_thr_shadow <= c_rst_thr;
            r_thr_act    <= c_rst_thr;
            r_en         <= 1'b0;
            r_rearm      <= 1'b0;
            r_exp_cnt    <= '0;
            r_csr_rdata  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_abs_cnt <= r_abs_cnt + c_one;
            r_elapsed <= w_elapsed_nxt;
            r_thr_act <= w_thr_act_nxt;
            if (w_start)
                r_begin_lat <= r_abs_cnt;
            if (w_expire && (r_exp_cnt != c_exp_ones))
                r_exp_cnt <= r_exp_cnt + c_exp_one;
            if (csr_we && (csr_addr == c_addr_thresh))
                r_thr_shadow <= csr_wdata;
            if (csr_we && (csr_addr == c_addr_ctrl)) begin
                r_en    <= csr_wdata[0];
                r_rearm <= csr_wdata[1];
            end
            if (csr_re)
                r_csr_rdata <= w_rd_mux;
        end
    end

    // Decider inputs are registered from next-state values so they line up
    // with the state register and never pass through output-side logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyclecounter  <= '0;
            r_begincycle    <= c_ones;
            r_threshold     <= '0;
            r_window_active <= 1'b0;
            r_expired_pulse <= 1'b0;
        end else begin
            r_window_active <= (w_state_nxt != c_st_idle);
            r_expired_pulse <= w_expire;
            if (w_state_nxt == c_st_idle) begin
                // begincycle all-ones keeps the decider sum saturated: never taken
                r_cyclecounter <= '0;
                r_begincycle   <= c_ones;
                r_threshold    <= '0;
            end else begin
                r_cyclecounter <= w_elapsed_nxt;
                r_begincycle   <= '0;
                r_threshold    <= w_thr_act_nxt;
            end
        end
    end

    assign csr_rdata     = r_csr_rdata;
    assign cyclecounter  = r_cyclecounter;
    assign begincycle    = r_begincycle;
    assign threshold     = r_threshold;
    assign window_active = r_window_active;
    assign expired_pulse = r_expired_pulse;

endmodule
`default_nettype wire

// File: tb/tb_ax_cycle_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ax_cycle_window_ctrl
//  Purpose  : Self-checking bench for ax_cycle_window_ctrl. CSR read results
//             and expiry latencies are queued when stimulus is driven and
//             compared when the DUT produces them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ax_cycle_window_ctrl;

    localparam int c_w = 32;
    localparam logic [63:0] c_ones32 = 64'h0000_0000_FFFF_FFFF;

    logic           clk;
    logic           rst_n;
    logic           region_begin;
    logic           region_end;
    logic           flush;
    logic           csr_we;
    logic           csr_re;
    logic [1:0]     csr_addr;
    logic [c_w-1:0] csr_wdata;
    logic [c_w-1:0] csr_rdata;
    logic [c_w-1:0] cyclecounter;
    logic [c_w-1:0] begincycle;
    logic [c_w-1:0] threshold;
    logic           window_active;
    logic           expired_pulse;

    ax_cycle_window_ctrl #(
        .CNT_WIDTH    (32),
        .RST_THRESHOLD(1000),
        .EXP_CNT_WIDTH(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .region_begin (region_begin),
        .region_end   (region_end),
        .flush        (flush),
        .csr_we       (csr_we),
        .csr_re       (csr_re),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata),
        .cyclecounter (cyclecounter),
        .begincycle   (begincycle),
        .threshold    (threshold),
        .window_active(window_active),
        .expired_pulse(expired_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } sb_entry_t;

    sb_entry_t   rd_q[$];
    sb_entry_t   lat_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    longint      cyc;
    longint      entry_cyc;
    logic [63:0] begin_exp;
    logic [63:0] exp_model;

    // Reference cycle count: edges seen since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic csr_write(input logic [1:0] addr, input logic [31:0] data);
        csr_we    = 1'b1;
        csr_addr  = addr;
        csr_wdata = data;
        step();
        csr_we    = 1'b0;
    endtask

    task automatic csr_read(input logic [1:0] addr, input string tag, input logic [63:0] expv);
        sb_entry_t e;
        sb_entry_t got;
        e.tag = tag;
        e.val = expv;
        rd_q.push_back(e);
        csr_re   = 1'b1;
        csr_addr = addr;
        step();
        csr_re   = 1'b0;
        got = rd_q.pop_front();
        check(got.tag, {32'b0, csr_rdata}, got.val);
    endtask

    task automatic pulse_in(input logic b, input logic e, input logic f);
        region_begin = b;
        region_end   = e;
        flush        = f;
        step();
        region_begin = 1'b0;
        region_end   = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic enter_window();
        begin_exp = 64'(cyc) & c_ones32;
        pulse_in(1'b1, 1'b0, 1'b0);
        entry_cyc = cyc;
    endtask

    task automatic push_lat(input string tag, input int lat);
        sb_entry_t e;
        e.tag = tag;
        e.val = 64'(lat);
        lat_q.push_back(e);
    endtask

    task automatic wait_expiry();
        sb_entry_t   got;
        logic [63:0] lat;
        lat = '1;
        for (int i = 0; i < 400; i++) begin
            if (expired_pulse) begin
                lat = 64'(cyc - entry_cyc);
                break;
            end
            step();
        end
        got = lat_q.pop_front();
        check(got.tag, lat, got.val);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_active"}, {63'b0, window_active}, 64'd0);
        check({tag, "_cc"},     {32'b0, cyclecounter},  64'd0);
        check({tag, "_bc"},     {32'b0, begincycle},    c_ones32);
        check({tag, "_thr"},    {32'b0, threshold},     64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; region_begin = 1'b0; region_end = 1'b0; flush = 1'b0;
        csr_we = 1'b0; csr_re = 1'b0; csr_addr = 2'd0; csr_wdata = '0;
        exp_model = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check_idle_outputs("rst");
        check("rst_pulse", {63'b0, expired_pulse}, 64'd0);
        csr_read(2'd0, "rst_thresh", 64'd1000);
        csr_read(2'd1, "rst_ctrl",   64'd0);
        csr_read(2'd2, "rst_status", 64'd0);
        csr_read(2'd3, "rst_begin",  64'd0);

        // Basic expiry with threshold 5
        csr_write(2'd1, 32'd1);
        csr_write(2'd0, 32'd5);
        csr_read(2'd0, "t2_thresh", 64'd5);
        csr_read(2'd1, "t2_ctrl",   64'd1);
        push_lat("t2_latency", 6);
        enter_window();
        check("t2_entry_active", {63'b0, window_active}, 64'd1);
        check("t2_entry_cc",  {32'b0, cyclecounter}, 64'd0);
        check("t2_entry_bc",  {32'b0, begincycle},   64'd0);
        check("t2_entry_thr", {32'b0, threshold},    64'd5);
        wait_expiry();
        check("t2_exp_cc",  {32'b0, cyclecounter}, 64'd6);
        check("t2_exp_thr", {32'b0, threshold},    64'd5);
        exp_model++;
        step();
        check("t2_pulse_width", {63'b0, expired_pulse}, 64'd0);
        check("t2_cc_counting", {32'b0, cyclecounter}, 64'd7);
        csr_read(2'd2, "t2_status", (exp_model << 16) | 64'd2);
        pulse_in(1'b0, 1'b1, 1'b0);
        check_idle_outputs("t2_end");

        // Threshold write mid-window does not affect the live compare
        csr_write(2'd0, 32'd10);
        push_lat("t3_latency_old_thr", 11);
        enter_window();
        csr_write(2'd0, 32'd3);
        csr_read(2'd0, "t3_shadow", 64'd3);
        check("t3_live_thr", {32'b0, threshold}, 64'd10);
        wait_expiry();
        exp_model++;
        pulse_in(1'b0, 1'b1, 1'b0);
        push_lat("t3_latency_new_thr", 4);
        enter_window();
        check("t3_new_thr", {32'b0, threshold}, 64'd3);
        wait_expiry();
        exp_model++;
        csr_read(2'd3, "t3_begin", begin_exp);
        pulse_in(1'b0, 1'b1, 1'b0);

        // Priority and EN clear
        enter_window();
        pulse_in(1'b1, 1'b1, 1'b1);
        check_idle_outputs("t4_all3");
        pulse_in(1'b1, 1'b1, 1'b0);
        check("t4_idle_be", {63'b0, window_active}, 64'd0);
        csr_read(2'd2, "t4_status", exp_model << 16);
        enter_window();
        csr_write(2'd1, 32'd0);
        check_idle_outputs("t4_en_clr");
        pulse_in(1'b1, 1'b0, 1'b0);
        check("t4_disabled_begin", {63'b0, window_active}, 64'd0);

        // Rearm in EXPIRED
        csr_write(2'd1, 32'd3);
        push_lat("t5_latency", 4);
        enter_window();
        wait_expiry();
        exp_model++;
        step();
        enter_window();
        check("t5_rearm_cc",    {32'b0, cyclecounter},  64'd0);
        check("t5_rearm_pulse", {63'b0, expired_pulse}, 64'd0);
        check("t5_rearm_thr",   {32'b0, threshold},     64'd3);
        csr_read(2'd2, "t5_status_active", (exp_model << 16) | 64'd1);
        push_lat("t5_latency_rearm", 4);
        wait_expiry();
        exp_model++;
        csr_write(2'd1, 32'd1);
        pulse_in(1'b1, 1'b0, 1'b0);
        check("t5_norearm_cc", {32'b0, cyclecounter}, 64'(cyc - entry_cyc));
        csr_read(2'd2, "t5_status_expired", (exp_model << 16) | 64'd2);
        pulse_in(1'b0, 1'b1, 1'b0);

        // Free-running counter near wrap, threshold 100
        csr_write(2'd0, 32'd100);
        force dut.r_abs_cnt = 32'hFFFF_FFF0;
        #1;
        release dut.r_abs_cnt;
        push_lat("t6_latency_wrap", 101);
        region_begin = 1'b1;
        step();
        region_begin = 1'b0;
        entry_cyc = cyc;
        wait_expiry();
        exp_model++;
        csr_read(2'd3, "t6_begin_wrap", 64'hFFFF_FFF0);
        pulse_in(1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-window
        enter_window();
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6_async_rst");
        check("t6_rst_pulse", {63'b0, expired_pulse}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        csr_read(2'd2, "t6_rst_status", 64'd0);
        csr_read(2'd0, "t6_rst_thresh", 64'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
